// File: rtl/mult_div_unit.sv
// Multi-cycle WIDTH-bit multiply/divide unit: shift-add multiply and restoring divide,
// one bit per RUN cycle, with a final sign-fixup cycle before the HI/LO result is presented.
module mult_div_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_MULT = 2'b10;
    localparam logic [1:0] OP_DIV  = 2'b11;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [1:0]       r_op;
    logic             r_sign_a;
    logic             r_sign_b;
    logic [WIDTH-1:0] r_mag_a;
    logic [WIDTH-1:0] r_mag_b;
    logic [WIDTH-1:0] r_orig_a;
    logic [WIDTH-1:0] r_acc_hi;
    logic [WIDTH-1:0] r_acc_lo;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_dbz;

    logic             w_accept;
    logic             w_is_div;
    logic             w_neg_a;
    logic             w_neg_b;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_fits;
    logic [WIDTH-1:0] w_step_hi;
    logic [WIDTH-1:0] w_step_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_fix_hi;
    logic [WIDTH-1:0] w_fix_lo;
    logic             w_b_zero;

    assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_is_div = r_op[0];

    // Signed ops run on magnitudes; the most-negative value maps to its unsigned magnitude.
    assign w_neg_a = op[1] & operand_a[WIDTH-1];
    assign w_neg_b = op[1] & operand_b[WIDTH-1];
    assign w_mag_a = w_neg_a ? -operand_a : operand_a;
    assign w_mag_b = w_neg_b ? -operand_b : operand_b;

    assign w_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_mag_a} : '0);
    assign w_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_mag_b};
    assign w_fits  = ~w_diff[WIDTH];

    always_comb begin
        // NOTE: defaults first on every comb-assigned signal so no path can infer a latch.
        w_step_hi = r_acc_hi;
        w_step_lo = r_acc_lo;
        if (w_is_div) begin
            w_step_hi = w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
            w_step_lo = {r_acc_lo[WIDTH-2:0], w_fits};
        end else begin
            w_step_hi = w_sum[WIDTH:1];
            w_step_lo = {w_sum[0], r_acc_lo[WIDTH-1:1]};
        end
    end

    assign w_b_zero = (r_mag_b == '0);

    always_comb begin
        w_prod   = {r_acc_hi, r_acc_lo};
        w_fix_hi = r_acc_hi;
        w_fix_lo = r_acc_lo;
        if (w_is_div) begin
            if (w_b_zero) begin
                w_fix_hi = r_orig_a;
                w_fix_lo = '1;
            end else begin
                w_fix_hi = (r_op == OP_DIV && r_sign_a) ? -r_acc_hi : r_acc_hi;
                w_fix_lo = (r_op == OP_DIV && (r_sign_a ^ r_sign_b)) ? -r_acc_lo : r_acc_lo;
            end
        end else begin
            if (r_op == OP_MULT && (r_sign_a ^ r_sign_b)) begin
                w_prod = -{r_acc_hi, r_acc_lo};
            end
            w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
            w_fix_lo = w_prod[WIDTH-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = S_RUN;
            S_RUN:  if (r_cnt == LAST) w_next = S_FIX;
            S_FIX:  w_next = S_DONE;
            S_DONE: w_next = start ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_RUN) || (r_state == S_FIX);
        done = (r_state == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_mag_a  <= '0;
            r_mag_b  <= '0;
            r_orig_a <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_dbz    <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_op     <= op;
            r_sign_a <= w_neg_a;
            r_sign_b <= w_neg_b;
            r_mag_a  <= w_mag_a;
            r_mag_b  <= w_mag_b;
            r_orig_a <= operand_a;
            r_acc_hi <= '0;
            r_acc_lo <= op[0] ? w_mag_a : w_mag_b;
            r_dbz    <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_cnt    <= r_cnt + 1'b1;
            r_acc_hi <= w_step_hi;
            r_acc_lo <= w_step_lo;
        end else if (r_state == S_FIX) begin
            r_hi  <= w_fix_hi;
            r_lo  <= w_fix_lo;
            r_dbz <= w_is_div & w_b_zero;
        end
    end

    assign hi          = r_hi;
    assign lo          = r_lo;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed results, latency, handshake and reset abort.
module tb_mult_div_unit;

    localparam logic [1:0] MULTU = 2'b00;
    localparam logic [1:0] DIVU  = 2'b01;
    localparam logic [1:0] MULT  = 2'b10;
    localparam logic [1:0] DIV   = 2'b11;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] op;
    logic [7:0] operand_a;
    logic [7:0] operand_b;
    logic       busy;
    logic       done;
    logic [7:0] hi;
    logic [7:0] lo;
    logic       div_by_zero;

    int n_cmp  = 0;
    int n_fail = 0;

    mult_div_unit #(.WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge one cycle after the accepting edge.
    task automatic issue(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b);
        start     = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        op        = ~o;
        operand_a = 8'h5A;
        operand_b = 8'hA5;
    endtask

    // k0 is the number of negedges already elapsed since the accepting edge.
    task automatic wait_done(input string tag, input int k0);
        int k = k0;
        while (done !== 1'b1 && k < 30) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_latency"}, k, 10);
    endtask

    task automatic check_res(input string tag, input logic [7:0] ehi, input logic [7:0] elo,
                             input logic edbz);
        check({tag, "_hi"}, hi, ehi);
        check({tag, "_lo"}, lo, elo);
        check({tag, "_dbz"}, div_by_zero, edbz);
    endtask

    initial begin
        int seen_done;
        reset     = 1'b1;
        start     = 1'b0;
        op        = 2'b00;
        operand_a = 8'h00;
        operand_b = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check_res("rst", 8'h00, 8'h00, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // MULTU 200 * 150 = 30000 = 0x7530, then hold in IDLE
        issue(MULTU, 8'hC8, 8'h96);
        check("mulu_busy", busy, 1);
        check("mulu_done_early", done, 0);
        wait_done("mulu", 1);
        check_res("mulu", 8'h75, 8'h30, 1'b0);
        @(negedge clk);
        check("mulu_hold_done", done, 0);
        check("mulu_hold_busy", busy, 0);
        check_res("mulu_hold", 8'h75, 8'h30, 1'b0);

        issue(DIVU, 8'hC8, 8'h07);
        wait_done("divu", 1);
        check_res("divu", 8'h04, 8'h1C, 1'b0);

        issue(DIV, 8'hF9, 8'h02);
        wait_done("div_neg", 1);
        check_res("div_neg", 8'hFF, 8'hFD, 1'b0);

        issue(MULT, 8'hFD, 8'h05);
        wait_done("mult_neg", 1);
        check_res("mult_neg", 8'hFF, 8'hF1, 1'b0);

        issue(MULT, 8'h80, 8'h80);
        wait_done("mult_min", 1);
        check_res("mult_min", 8'h40, 8'h00, 1'b0);

        issue(DIVU, 8'h2A, 8'h00);
        wait_done("divz", 1);
        check_res("divz", 8'h2A, 8'hFF, 1'b1);

        // Next accept clears div_by_zero immediately
        issue(MULTU, 8'h10, 8'h10);
        check("dbz_clear", div_by_zero, 0);
        wait_done("mulu_16", 1);
        check_res("mulu_16", 8'h01, 8'h00, 1'b0);

        issue(DIV, 8'h80, 8'hFF);
        wait_done("div_wrap", 1);
        check_res("div_wrap", 8'h00, 8'h80, 1'b0);

        // Start pulsed three cycles into RUN must be ignored
        @(negedge clk);
        issue(MULTU, 8'h0A, 8'h0C);
        repeat (2) @(negedge clk);
        start     = 1'b1;
        op        = DIVU;
        operand_a = 8'h63;
        operand_b = 8'h03;
        @(negedge clk);
        start     = 1'b0;
        wait_done("ignore", 4);
        check_res("ignore", 8'h00, 8'h78, 1'b0);

        // Start in the done cycle is accepted with no IDLE gap
        issue(DIVU, 8'h63, 8'h03);
        check("b2b_busy", busy, 1);
        check("b2b_done", done, 0);
        wait_done("b2b", 1);
        check_res("b2b", 8'h00, 8'h21, 1'b0);

        // Reset four cycles into RUN aborts at once
        issue(MULTU, 8'hFF, 8'hFF);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check_res("abort", 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen_done++;
        end
        check("abort_no_done", seen_done, 0);
        check("abort_idle_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
